// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin sharing of one A2D_intf converter among NUM_REQ requesters.
// Optional conversion watchdog enabled by defining A2D_ARB_TIMEOUT_EN.
module a2d_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TMO_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [11:0]          res_out,
  output logic                 err,
  output logic                 busy,
  output logic                 a2d_strt_cnv,
  output logic [2:0]           a2d_chnnl,
  input  logic                 a2d_cnv_cmplt,
  input  logic [11:0]          a2d_res
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TMO_CYCLES < 1) begin : g_bad_cfg
    $error("a2d_arbiter: NUM_REQ must be 2..8 and TMO_CYCLES >= 1");
  end
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d, win, lo, hi;
  logic              hi_v, tmo;
  logic [11:0]       res_q, res_d;
  logic [2:0]        ch_q, ch_d, ch_sel;
  // Lowest set bit at or above the pointer wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    lo = '0;
    hi = '0;
    hi_v = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) lo = IW'(j);
      if (req[j] && IW'(j) >= ptr_q) begin
        hi = IW'(j);
        hi_v = 1'b1;
      end
    end
  end
  assign win = hi_v ? hi : lo;
  always_comb begin
    ch_sel = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (IW'(j) == win) ch_sel = req_chnnl[3*j +: 3];
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    res_d   = res_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = START;
        idx_d   = win;
        gnt_d   = NUM_REQ'(1) << win;
        ch_d    = ch_sel;
      end
      START: state_d = WAIT;
      WAIT: if (a2d_cnv_cmplt || tmo) begin
        state_d = DONE;
        res_d   = a2d_cnv_cmplt ? a2d_res : 12'hFFF;
        done_d  = gnt_q & req;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ch_q    <= ch_d;
    end
  end
`ifdef A2D_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign tmo = (state_q == WAIT) && (cnt_q == CW'(TMO_CYCLES - 1));
  // Counter is zero on WAIT entry because it is held clear in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      err_q <= (tmo && !a2d_cnv_cmplt) ? 1'b1 : (state_q == IDLE && |req) ? 1'b0 : err_q;
    end
  end
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  assign gnt          = gnt_q;
  assign done         = done_q;
  assign res_out      = res_q;
  assign a2d_chnnl    = ch_q;
  assign busy         = (state_q != IDLE);
  assign a2d_strt_cnv = (state_q == START);
endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: table-driven check of grant order, handshake timing, reset and watchdog.
module tb_a2d_arbiter;
  logic        clk = 1'b0, rst;
  logic [3:0]  req, gnt, done;
  logic [11:0] req_chnnl, res_out, a2d_res;
  logic        err, busy, a2d_strt_cnv, a2d_cnv_cmplt;
  logic [2:0]  a2d_chnnl;
  int total = 0, bad = 0;
  localparam logic [11:0] CH = {3'd7, 3'd6, 3'd5, 3'd2};
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [2:0]  ch;
    int          lat;
    logic [11:0] res;
    bit          wd;
  } vec_t;
  vec_t vt[12];
  always #5 clk = ~clk;
  a2d_arbiter #(.NUM_REQ(4), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_chnnl(req_chnnl), .gnt(gnt), .done(done),
    .res_out(res_out), .err(err), .busy(busy), .a2d_strt_cnv(a2d_strt_cnv),
    .a2d_chnnl(a2d_chnnl), .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset_vals();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res_out, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strt", a2d_strt_cnv, 0);
    chk("rst_chnnl", a2d_chnnl, 0);
  endtask
  task automatic run(input vec_t v);
    req = v.req;
    @(negedge clk);
    chk("gnt", gnt, v.gnt);
    chk("chnnl", a2d_chnnl, v.ch);
    chk("strt", a2d_strt_cnv, 1);
    chk("busy", busy, 1);
    chk("err_grant", err, 0);
    req_chnnl = ~req_chnnl;
    @(negedge clk);
    chk("strt_once", a2d_strt_cnv, 0);
    chk("gnt_held", gnt, v.gnt);
    if (v.wd) req = req & ~v.gnt;
    repeat (v.lat - 1) @(negedge clk);
    chk("no_done_wait", done, 0);
    a2d_cnv_cmplt = 1'b1;
    a2d_res = v.res;
    @(negedge clk);
    a2d_cnv_cmplt = 1'b0;
    a2d_res = 12'h000;
    chk("done", done, v.wd ? 4'b0000 : v.gnt);
    chk("res_out", res_out, v.res);
    chk("strt_vs_done", a2d_strt_cnv, 0);
    chk("chnnl_latched", a2d_chnnl, v.ch);
    chk("err_done", err, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    chk("gnt_clr", gnt, 0);
    chk("chnnl_hold", a2d_chnnl, v.ch);
    req = req & ~v.gnt;
    req_chnnl = CH;
  endtask
  initial begin
    vt = '{
      '{4'b0010, 4'b0010, 3'd5, 40, 12'h3A7, 1'b0},
      '{4'b1111, 4'b0100, 3'd6,  3, 12'h111, 1'b0},
      '{4'b1111, 4'b1000, 3'd7,  1, 12'h222, 1'b0},
      '{4'b1111, 4'b0001, 3'd2,  5, 12'h333, 1'b0},
      '{4'b1111, 4'b0010, 3'd5,  2, 12'h444, 1'b0},
      '{4'b1111, 4'b0100, 3'd6,  4, 12'h555, 1'b0},
      '{4'b1111, 4'b1000, 3'd7,  2, 12'h666, 1'b0},
      '{4'b1001, 4'b0001, 3'd2,  3, 12'h777, 1'b0},
      '{4'b1001, 4'b1000, 3'd7,  2, 12'h888, 1'b0},
      '{4'b1100, 4'b0100, 3'd6,  6, 12'h999, 1'b1},
      '{4'b1000, 4'b1000, 3'd7,  2, 12'hAAA, 1'b0},
      '{4'b0001, 4'b0001, 3'd2,  2, 12'hBBB, 1'b0}
    };
    rst = 1'b1;
    req = '0;
    req_chnnl = CH;
    a2d_cnv_cmplt = 1'b0;
    a2d_res = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) run(vt[i]);
    // Pointer now sits at 1; a reset in WAIT must return it to 0.
    req = 4'b0100;
    @(negedge clk);
    chk("rst_seq_gnt", gnt, 4'b0100);
    @(negedge clk);
    chk("rst_seq_wait", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    run('{4'b1111, 4'b0001, 3'd2, 3, 12'hCCC, 1'b0});
`ifdef A2D_ARB_TIMEOUT_EN
    req = 4'b0010;
    @(negedge clk);
    chk("wdg_gnt", gnt, 4'b0010);
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("wdg_not_yet", done, 0);
    chk("wdg_busy", busy, 1);
    @(negedge clk);
    chk("wdg_done", done, 4'b0010);
    chk("wdg_res", res_out, 12'hFFF);
    chk("wdg_err", err, 1);
    @(negedge clk);
    chk("wdg_idle", busy, 0);
    chk("wdg_err_hold", err, 1);
    req = 4'b0000;
    run('{4'b0001, 4'b0001, 3'd2, 2, 12'hDDD, 1'b0});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
